// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo position controller.
package servo_pkg;

  // Largest legal angle command in degrees
  localparam int unsigned ANGLE_MAX = 180;

  // Width of the duty_cycle / period datapath
  localparam int unsigned DUTY_W = 32;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } servo_state_e;

endpackage

// File: rtl/servo_frame_tick.sv
// Free-running frame counter. It asserts tick in the last cycle of each
// PWM frame. Released from reset together with the PWM, so both stay aligned.
module servo_frame_tick #(
  parameter int unsigned PERIOD_CLKS = 500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..PERIOD_CLKS-1, then wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_position_ctrl.sv
// Servo angle to PWM duty converter with per-frame slew limiting.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready drops only during the one-cycle LOAD.
// duty_cycle changes only on frame ticks, so the PWM never sees a mid-frame edit.
module servo_position_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CLKS    = 500000,
  parameter int unsigned MIN_PULSE_CLKS = 25000,
  parameter int unsigned STEP_PER_DEG   = 139,
  parameter int unsigned RAMP_STEP      = 500,
  parameter int unsigned INIT_ANGLE     = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_angle,
  output logic              cmd_clamped,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [DUTY_W-1:0] period,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] INIT_DUTY = DUTY_W'(MIN_PULSE_CLKS + INIT_ANGLE * STEP_PER_DEG);
  localparam logic [DUTY_W-1:0] STEP_W    = DUTY_W'(RAMP_STEP);
  localparam logic [7:0]        ANGLE_LIM = 8'(ANGLE_MAX);
  localparam logic [7:0]        INIT_ANG  = 8'(INIT_ANGLE);

  servo_state_e      state;
  logic [7:0]        angle_q;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] duty;
  logic              clamp_q;
  logic              tick;
  logic              accept;
  logic [DUTY_W-1:0] new_target;
  logic [DUTY_W-1:0] diff;
  logic [DUTY_W-1:0] duty_step;
  logic [DUTY_W-1:0] duty_next;

  servo_frame_tick #(
    .PERIOD_CLKS(PERIOD_CLKS)
  ) u_frame_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign period      = DUTY_W'(PERIOD_CLKS);
  assign cmd_ready   = (state != LOAD);
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state != IDLE);
  assign duty_cycle  = duty;
  assign cmd_clamped = clamp_q;

  // Target pulse width for the latched angle
  assign new_target = DUTY_W'(MIN_PULSE_CLKS) + DUTY_W'(angle_q) * DUTY_W'(STEP_PER_DEG);

  // One slew step toward the current target; lands exactly when close enough
  always_comb begin
    diff      = (target > duty) ? (target - duty) : (duty - target);
    duty_step = target;
    if ((RAMP_STEP != 0) && (diff > STEP_W)) begin
      duty_step = (target > duty) ? (duty + STEP_W) : (duty - STEP_W);
    end
  end

  // Value duty will hold after this edge; LOAD compares against it
  assign duty_next = tick ? duty_step : duty;

  // Controller state: accept wins, LOAD decides IDLE/RAMP, RAMP ends on arrival
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (accept) begin
      state <= LOAD;
    end else begin
      case (state)
        LOAD:    state <= (new_target == duty_next) ? IDLE : RAMP;
        RAMP:    if (tick && (duty_step == target)) state <= IDLE;
        default: state <= state;
      endcase
    end
  end

  // Latch the clamped angle and flag out-of-range commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q <= INIT_ANG;
      clamp_q <= 1'b0;
    end else begin
      clamp_q <= accept && (cmd_angle > ANGLE_LIM);
      if (accept) begin
        angle_q <= (cmd_angle > ANGLE_LIM) ? ANGLE_LIM : cmd_angle;
      end
    end
  end

  // Target is rewritten only in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= INIT_DUTY;
    end else if (state == LOAD) begin
      target <= new_target;
    end
  end

  // Duty steps on frame ticks toward whatever target is current at that tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= INIT_DUTY;
    end else if (tick) begin
      duty <= duty_step;
    end
  end

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Directed bench for servo_position_ctrl: table of commands plus hand sequences
// for retargeting, tick/accept collisions, async reset and the no-ramp variant.
module tb_servo_position_ctrl;

  localparam int unsigned PER = 400;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_valid0;
  logic        cmd_ready, cmd_ready0;
  logic [7:0]  cmd_angle, cmd_angle0;
  logic        cmd_clamped, cmd_clamped0;
  logic [31:0] duty_cycle, duty_cycle0;
  logic [31:0] period, period0;
  logic        busy, busy0;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned fc;

  typedef struct {
    logic [7:0]  angle;
    logic        exp_clamp;
    logic [31:0] exp_final;
    int unsigned exp_ticks;
  } vec_t;

  vec_t vecs[6];

  servo_position_ctrl #(
    .PERIOD_CLKS(PER), .MIN_PULSE_CLKS(20), .STEP_PER_DEG(1),
    .RAMP_STEP(16), .INIT_ANGLE(90)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle), .cmd_clamped(cmd_clamped), .duty_cycle(duty_cycle),
    .period(period), .busy(busy)
  );

  servo_position_ctrl #(
    .PERIOD_CLKS(PER), .MIN_PULSE_CLKS(20), .STEP_PER_DEG(1),
    .RAMP_STEP(0), .INIT_ANGLE(90)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_angle(cmd_angle0), .cmd_clamped(cmd_clamped0), .duty_cycle(duty_cycle0),
    .period(period0), .busy(busy0)
  );

  // Clock and reference frame position
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fc <= 0;
    else        fc <= (fc == PER - 1) ? 0 : fc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference slew step with a 16-clock limit
  function automatic logic [31:0] ref_step(input logic [31:0] d, input logic [31:0] t);
    if (t > d) return (t - d <= 16) ? t : d + 16;
    else       return (d - t <= 16) ? t : d - 16;
  endfunction

  // Wait at negedges until the reference frame sits in its tick cycle
  task automatic wait_tick_cycle();
    int unsigned n = 0;
    while (fc != PER - 1 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (fc != PER - 1) chk("tick_timeout", 0, 1);
  endtask

  // Let the next tick edge pass; returns at the following negedge
  task automatic pass_tick();
    wait_tick_cycle();
    @(negedge clk);
  endtask

  task automatic wait_frame_pos(input int unsigned pos);
    int unsigned n = 0;
    while (fc != pos && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (fc != pos) chk("pos_timeout", 0, 1);
  endtask

  // One-cycle command pulse on the ramped instance, launched at a negedge
  task automatic send_cmd(input logic [7:0] a);
    cmd_valid = 1'b1;
    cmd_angle = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic [31:0] tgt;

    cmd_valid = 0; cmd_angle = 0; cmd_valid0 = 0; cmd_angle0 = 0;
    rst_n = 1'b0;
    vecs[0] = '{8'd90,  1'b0, 32'd110, 0};
    vecs[1] = '{8'd0,   1'b0, 32'd20,  6};
    vecs[2] = '{8'd250, 1'b1, 32'd200, 12};
    vecs[3] = '{8'd180, 1'b0, 32'd200, 0};
    vecs[4] = '{8'd181, 1'b1, 32'd200, 0};
    vecs[5] = '{8'd100, 1'b0, 32'd120, 5};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_duty", duty_cycle, 110);
    chk("rst_period", period, 400);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_clamped", cmd_clamped, 0);
    chk("rst_duty0", duty_cycle0, 110);
    for (int f = 0; f < 3; f++) begin
      pass_tick();
      chk("idle_frame_duty", duty_cycle, 110);
      chk("idle_frame_busy", busy, 0);
    end

    // Table of commands, each run to completion from IDLE
    exp_d = 110;
    for (int i = 0; i < 6; i++) begin
      tgt = vecs[i].exp_final;
      wait_frame_pos(10);
      chk("pre_ready", cmd_ready, 1);
      send_cmd(vecs[i].angle);
      chk("load_ready", cmd_ready, 0);
      chk("load_busy", busy, 1);
      chk("clamp_pulse", cmd_clamped, vecs[i].exp_clamp);
      chk("load_duty", duty_cycle, exp_d);
      @(negedge clk);
      chk("post_ready", cmd_ready, 1);
      chk("clamp_clear", cmd_clamped, 0);
      chk("post_busy", busy, vecs[i].exp_ticks > 0);
      for (int k = 1; k <= vecs[i].exp_ticks; k++) begin
        pass_tick();
        exp_d = ref_step(exp_d, tgt);
        chk("ramp_duty", duty_cycle, exp_d);
        chk("ramp_busy", busy, k < vecs[i].exp_ticks);
      end
      chk("final_duty", duty_cycle, vecs[i].exp_final);
      chk("final_busy", busy, 0);
    end

    // Mid-ramp retarget: 110 -> 0, at 78 command 180, next tick gives 94
    do_reset();
    chk("rst2_duty", duty_cycle, 110);
    wait_frame_pos(10);
    send_cmd(8'd0);
    pass_tick(); chk("rt_94", duty_cycle, 94);
    pass_tick(); chk("rt_78", duty_cycle, 78);
    wait_frame_pos(10);
    send_cmd(8'd180);
    chk("rt_hold", duty_cycle, 78);
    pass_tick(); chk("rt_up_94", duty_cycle, 94);

    // Accept on the tick cycle: that tick still heads to the old target (200)
    wait_tick_cycle();
    cmd_valid = 1'b1; cmd_angle = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("acc_tick_duty", duty_cycle, 110);
    chk("acc_tick_busy", busy, 1);
    pass_tick(); chk("acc_tick_next", duty_cycle, 94);

    // Tick during LOAD: step toward old target 20, then toward new 200
    wait_frame_pos(PER - 2);
    send_cmd(8'd180);
    chk("tick_load_state", cmd_ready, 0);
    @(negedge clk);
    chk("tick_load_duty", duty_cycle, 78);
    chk("tick_load_busy", busy, 1);
    pass_tick(); chk("tick_load_next", duty_cycle, 94);

    // Asynchronous reset mid-ramp
    wait_frame_pos(100);
    rst_n = 1'b0;
    #1;
    chk("arst_duty", duty_cycle, 110);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    pass_tick();
    chk("arst_hold", duty_cycle, 110);

    // RAMP_STEP = 0 instance jumps in a single tick
    wait_frame_pos(10);
    cmd_valid0 = 1'b1; cmd_angle0 = 8'd180;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    chk("jump_load_busy", busy0, 1);
    @(negedge clk);
    chk("jump_pre_duty", duty_cycle0, 110);
    chk("jump_pre_busy", busy0, 1);
    pass_tick();
    chk("jump_duty", duty_cycle0, 200);
    chk("jump_busy", busy0, 0);
    chk("jump_period", period0, 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
